// File: rtl/keypad_lock_pkg.sv
// keypad_lock_pkg: shared FSM state, keypad strobe decoding and width helper for the keypad lock.
package keypad_lock_pkg;
  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_DENIED,
    ST_LOCKOUT,
    ST_PROG
  } state_e;
  typedef enum logic [1:0] {
    STB_NONE,
    STB_DIGIT,
    STB_ENTER,
    STB_CLEAR
  } strobe_e;
  // clear beats enter beats digit; the losers are simply dropped
  function automatic strobe_e decode_strobe(input logic valid, input logic enter, input logic clear);
    return clear ? STB_CLEAR : enter ? STB_ENTER : valid ? STB_DIGIT : STB_NONE;
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter flagging expiry on its last counted cycle.
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else if (load_i) cnt_q <= value_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign expired_o = cnt_q == W'(1);
endmodule

// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl: digit-serial keypad lock with timed open window, failure lockout and code programming.
module keypad_lock_ctrl
  import keypad_lock_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int NUM_DIGITS  = 4,
  parameter int MAX_TRIES   = 3,
  parameter int OPEN_CYCLES = 100,
  parameter int LOCK_CYCLES = 1000,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] RESET_CODE = 16'h1234
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              key_valid,
  input  logic [DIGIT_W-1:0]                key_digit,
  input  logic                              key_enter,
  input  logic                              key_clear,
  input  logic                              prog_req,
  output logic                              access,
  output logic                              alarm,
  output logic                              prog_mode,
  output logic [clog2(MAX_TRIES+1)-1:0]     fail_count
);
  localparam int CODE_W  = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W   = clog2(NUM_DIGITS + 1);
  localparam int FAIL_W  = clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = OPEN_CYCLES > LOCK_CYCLES ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TMR_W   = clog2(TMR_MAX + 1);
  state_e              state_q, state_d;
  logic                valid_q, enter_q, clear_q, prog_q;
  logic [DIGIT_W-1:0]  digit_q;
  logic [CODE_W-1:0]   buf_q, buf_d, col_buf, code_q, code_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, col_cnt;
  logic                ovf_q, ovf_d, col_ovf;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic                tmr_load, tmr_exp, full, match;
  logic [TMR_W-1:0]    tmr_val;
  strobe_e             stb;
  // keypad strobes pass through one register stage before the FSM sees them
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_q <= 1'b0;
      enter_q <= 1'b0;
      clear_q <= 1'b0;
      prog_q  <= 1'b0;
      digit_q <= '0;
    end else begin
      valid_q <= key_valid;
      enter_q <= key_enter;
      clear_q <= key_clear;
      prog_q  <= prog_req;
      digit_q <= key_digit;
    end
  assign stb   = decode_strobe(valid_q, enter_q, clear_q);
  assign full  = cnt_q == CNT_W'(NUM_DIGITS) && !ovf_q;
  assign match = full && buf_q == code_q;
  always_comb begin
    col_buf = buf_q;
    col_cnt = cnt_q;
    col_ovf = ovf_q;
    if (stb == STB_CLEAR) begin
      col_buf = '0;
      col_cnt = '0;
      col_ovf = 1'b0;
    end else if (stb == STB_DIGIT && cnt_q == CNT_W'(NUM_DIGITS)) col_ovf = 1'b1;
    else if (stb == STB_DIGIT) begin
      col_buf = (buf_q << DIGIT_W) | CODE_W'(digit_q);
      col_cnt = cnt_q + 1'b1;
    end
  end
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    code_d   = code_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_ENTRY: begin
        {buf_d, cnt_d, ovf_d} = {col_buf, col_cnt, col_ovf};
        state_d = stb == STB_ENTER ? ST_CHECK : ST_ENTRY;
      end
      ST_CHECK: begin
        {buf_d, cnt_d, ovf_d} = '0;
        state_d  = match ? ST_OPEN : ST_DENIED;
        fail_d   = match ? '0 : fail_q == FAIL_W'(MAX_TRIES) ? fail_q : fail_q + 1'b1;
        tmr_load = match;
        tmr_val  = TMR_W'(OPEN_CYCLES);
      end
      ST_OPEN: state_d = prog_q ? ST_PROG : tmr_exp ? ST_ENTRY : ST_OPEN;
      ST_DENIED: begin
        state_d  = fail_q == FAIL_W'(MAX_TRIES) ? ST_LOCKOUT : ST_ENTRY;
        tmr_load = fail_q == FAIL_W'(MAX_TRIES);
        tmr_val  = TMR_W'(LOCK_CYCLES);
      end
      ST_LOCKOUT: begin
        state_d = tmr_exp ? ST_ENTRY : ST_LOCKOUT;
        fail_d  = tmr_exp ? '0 : fail_q;
      end
      ST_PROG: begin
        {buf_d, cnt_d, ovf_d} = stb == STB_ENTER ? '0 : {col_buf, col_cnt, col_ovf};
        code_d  = stb == STB_ENTER && full ? buf_q : code_q;
        state_d = stb == STB_ENTER ? ST_ENTRY : ST_PROG;
      end
      default: state_d = ST_ENTRY;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= ST_ENTRY;
      buf_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      code_q     <= RESET_CODE;
      fail_q     <= '0;
      access     <= 1'b0;
      alarm      <= 1'b0;
      prog_mode  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      code_q     <= code_d;
      fail_q     <= fail_d;
      access     <= state_d == ST_OPEN;
      alarm      <= state_d == ST_LOCKOUT;
      prog_mode  <= state_d == ST_PROG;
    end
  assign fail_count = fail_q;
  lock_timer #(.W(TMR_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .value_i   (tmr_val),
    .expired_o (tmr_exp)
  );
endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb_keypad_lock_ctrl: directed and randomized entry attempts against a transaction-level lock model.
module tb_keypad_lock_ctrl;
  localparam int ND = 4;
  localparam int MT = 3;
  localparam int OC = 5;
  localparam int LC = 8;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0, key_enter = 1'b0, key_clear = 1'b0, prog_req = 1'b0;
  logic [3:0] key_digit = '0;
  logic       access, alarm, prog_mode;
  logic [1:0] fail_count;
  int         checks = 0;
  int         errors = 0;
  int         code_m[$];
  int         buf_m[$];
  bit         ovf_m;
  int         fails_m;
  bit         in_prog;

  keypad_lock_ctrl #(
    .DIGIT_W(4), .NUM_DIGITS(ND), .MAX_TRIES(MT), .OPEN_CYCLES(OC), .LOCK_CYCLES(LC),
    .RESET_CODE(16'h1234)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
    .key_enter(key_enter), .key_clear(key_clear), .prog_req(prog_req),
    .access(access), .alarm(alarm), .prog_mode(prog_mode), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    code_m = '{1, 2, 3, 4};
    buf_m.delete();
    ovf_m = 1'b0;
    fails_m = 0;
    in_prog = 1'b0;
  endtask

  function automatic bit code_ok(input bit cmp);
    if (ovf_m || buf_m.size() != ND) return 1'b0;
    if (cmp) foreach (buf_m[i]) if (buf_m[i] != code_m[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic press(input int d);
    key_valid = 1'b1;
    key_digit = 4'(d);
    tick;
    key_valid = 1'b0;
    if (buf_m.size() < ND) buf_m.push_back(d);
    else ovf_m = 1'b1;
  endtask

  task automatic press_seq(input int q[$]);
    foreach (q[i]) press(q[i]);
  endtask

  task automatic clr;
    key_clear = 1'b1;
    tick;
    key_clear = 1'b0;
    buf_m.delete();
    ovf_m = 1'b0;
  endtask

  // Enter (optionally with a simultaneous, dropped digit) and follow the whole outcome timeline.
  task automatic attempt(input bit do_prog, input bit with_key, input int kd);
    bit m;
    m = code_ok(1'b1);
    key_enter = 1'b1;
    key_valid = with_key;
    key_digit = 4'(kd);
    tick;
    key_enter = 1'b0;
    key_valid = 1'b0;
    buf_m.delete();
    ovf_m = 1'b0;
    in_prog = 1'b0;
    tick;
    chk("check_access", access, 0);
    chk("check_alarm", alarm, 0);
    tick;
    if (m) begin
      fails_m = 0;
      chk("open_access", access, 1);
      chk("open_fails", fail_count, 0);
      if (do_prog) begin
        prog_req = 1'b1;
        tick;
        prog_req = 1'b0;
        chk("prog_req_access", access, 1);
        tick;
        chk("prog_access", access, 0);
        chk("prog_mode", prog_mode, 1);
        in_prog = 1'b1;
      end else
        for (int i = 1; i <= OC; i++) begin
          tick;
          chk("open_window", access, 32'(i < OC));
        end
    end else begin
      fails_m = fails_m < MT ? fails_m + 1 : MT;
      chk("denied_fails", fail_count, fails_m);
      chk("denied_access", access, 0);
      tick;
      if (fails_m == MT) begin
        chk("lock_alarm", alarm, 1);
        for (int i = 1; i <= LC; i++) begin
          key_valid = (i <= LC - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
          key_enter = (i <= LC - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
          key_clear = (i <= LC - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
          prog_req  = (i <= LC - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
          key_digit = 4'($urandom_range(0, 15));
          tick;
          chk("lock_window", alarm, 32'(i < LC));
        end
        {key_valid, key_enter, key_clear, prog_req} = '0;
        fails_m = 0;
        chk("lock_fails", fail_count, 0);
        chk("lock_access", access, 0);
      end else chk("denied_alarm", alarm, 0);
    end
  endtask

  task automatic prog_enter;
    bit ok;
    ok = code_ok(1'b0);
    key_enter = 1'b1;
    tick;
    key_enter = 1'b0;
    tick;
    chk("prog_exit_mode", prog_mode, 0);
    chk("prog_exit_access", access, 0);
    if (ok) code_m = buf_m;
    buf_m.delete();
    ovf_m = 1'b0;
    in_prog = 1'b0;
  endtask

  initial begin
    model_reset();
    tick;
    tick;
    chk("rst_access", access, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_prog", prog_mode, 0);
    chk("rst_fails", fail_count, 0);
    reset = 1'b0;
    tick;
    press_seq('{1, 2, 3, 4}); attempt(0, 0, 0);
    repeat (3) begin press_seq('{1, 2, 3, 5}); attempt(0, 0, 0); end
    press_seq('{1, 2, 3, 4}); attempt(0, 0, 0);
    press_seq('{1, 2, 3}); attempt(0, 0, 0);
    press_seq('{1, 2, 3, 4, 4}); attempt(0, 0, 0);
    press_seq('{1, 2, 3, 4}); attempt(0, 0, 0);
    press_seq('{9, 9}); clr(); press_seq('{1, 2, 3, 4}); attempt(0, 0, 0);
    press_seq('{1, 2, 3}); attempt(0, 1, 4);
    press_seq('{1, 2, 3, 4}); attempt(0, 1, 9);
    press_seq('{1, 2, 3, 4}); attempt(1, 0, 0);
    press_seq('{5, 6, 7, 8}); prog_enter();
    press_seq('{1, 2, 3, 4}); attempt(0, 0, 0);
    press_seq('{5, 6, 7, 8}); attempt(1, 0, 0);
    press_seq('{9, 9}); prog_enter();
    press_seq('{5, 6, 7, 8}); attempt(0, 0, 0);
    repeat (2) begin press_seq('{1, 2, 3, 5}); attempt(0, 0, 0); end
    press_seq('{1, 2, 3, 5});
    key_enter = 1'b1; tick; key_enter = 1'b0;
    tick; tick;
    chk("pre_rst_fails", fail_count, 3);
    tick;
    chk("pre_rst_alarm", alarm, 1);
    tick; tick; tick;
    reset = 1'b1;
    #2;
    chk("async_rst_alarm", alarm, 0);
    chk("async_rst_fails", fail_count, 0);
    reset = 1'b0;
    model_reset();
    tick;
    press_seq('{1, 2, 3, 4}); attempt(1, 0, 0);
    press_seq('{5, 6, 7, 8}); prog_enter();
    press_seq('{1, 2, 3, 4}); attempt(0, 0, 0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    tick;
    press_seq('{1, 2, 3, 4}); attempt(0, 0, 0);
    repeat (40) begin
      case ($urandom_range(0, 3))
        0: press_seq(code_m);
        1: begin
          int p;
          p = $urandom_range(0, ND - 1);
          for (int i = 0; i < ND; i++)
            press(i == p ? (code_m[i] + 1 + int'($urandom_range(0, 14))) % 16 : code_m[i]);
        end
        2: repeat ($urandom_range(0, 6)) press($urandom_range(0, 15));
        default: begin
          repeat ($urandom_range(1, 5)) press($urandom_range(0, 15));
          clr();
          press_seq(code_m);
        end
      endcase
      attempt(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 15));
      if (in_prog) begin
        repeat ($urandom_range(3, 5)) press($urandom_range(0, 15));
        prog_enter();
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
